// File: rtl/processor_pkg.sv
// processor_pkg: opcode constants and FSM states shared by the sequencer
package processor_pkg;
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_STEP = 2'b01;
    localparam logic [1:0] OP_JUMP = 2'b10;
    localparam logic [1:0] OP_WAIT = 2'b11;
    typedef enum logic {ST_READY, ST_WAITING} fsm_t;
endpackage

// File: rtl/processor_seq_if.sv
// processor_seq_if: valid/ready instruction port between fetch and sequencer
interface processor_seq_if #(parameter int STATE_W = 4);
    logic               instr_valid;
    logic [1:0]         instr;
    logic [STATE_W-1:0] target;
    logic               instr_ready;
    modport master (output instr_valid, instr, target, input instr_ready);
    modport slave (input instr_valid, instr, target, output instr_ready);
endinterface

// File: rtl/processor_wait_ctr.sv
// processor_wait_ctr: loadable down-counter timing the WAIT opcode
module processor_wait_ctr #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               load,
    input  logic [STATE_W-1:0] din,
    output logic               zero_next
);
    logic [STATE_W-1:0] cnt;
    assign zero_next = cnt == STATE_W'(1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (load) cnt <= din;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/processor_seq.sv
// processor_seq: instruction-driven state sequencer with HOLD/STEP/JUMP/WAIT
module processor_seq
    import processor_pkg::*;
#(
    parameter int                 STATE_W    = 4,
    parameter logic [STATE_W-1:0] INIT_STATE = '0,
    parameter logic [STATE_W-1:0] LAST_STATE = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    processor_seq_if.slave     bus,
    output logic [STATE_W-1:0] state,
    output logic               wrap,
    output logic               err,
    output logic               wait_done
);
    fsm_t               fsm, fsm_n;
    logic [STATE_W-1:0] state_n;
    logic               wrap_n, err_n, done_n, accept, load, zero_next;
    assign bus.instr_ready = fsm == ST_READY;
    assign accept = clk_en & bus.instr_valid & bus.instr_ready;
    assign load = accept && bus.instr == OP_WAIT && bus.target != '0;
    processor_wait_ctr #(.STATE_W(STATE_W)) u_ctr (
        .clk(clk),
        .reset(reset),
        .en(clk_en && fsm == ST_WAITING),
        .load(load),
        .din(bus.target),
        .zero_next(zero_next)
    );
    always_comb begin
        state_n = state;
        fsm_n = fsm;
        wrap_n = 1'b0;
        err_n = 1'b0;
        done_n = 1'b0;
        if (fsm == ST_WAITING) begin
            done_n = zero_next;
            fsm_n = zero_next ? ST_READY : ST_WAITING;
        end else if (accept) begin
            case (bus.instr)
                OP_STEP: begin
                    // states above LAST_STATE also wrap back to INIT_STATE
                    wrap_n = state >= LAST_STATE;
                    state_n = wrap_n ? INIT_STATE : state + 1'b1;
                end
                OP_JUMP: begin
                    err_n = bus.target > LAST_STATE;
                    state_n = err_n ? state : bus.target;
                end
                OP_WAIT: begin
                    done_n = bus.target == '0;
                    fsm_n = done_n ? ST_READY : ST_WAITING;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm <= ST_READY;
            state <= INIT_STATE;
            wrap <= 1'b0;
            err <= 1'b0;
            wait_done <= 1'b0;
        end else if (clk_en) begin
            fsm <= fsm_n;
            state <= state_n;
            wrap <= wrap_n;
            err <= err_n;
            wait_done <= done_n;
        end
    end
endmodule

// File: tb/tb_processor_seq.sv
// tb_processor_seq: two sequencers (LAST_STATE 15 and 11) checked against a behavioural model
module tb_processor_seq;
    import processor_pkg::*;
    logic       clk = 0, rst_n = 0, en = 0, valid = 0, go = 0;
    logic [1:0] op = 0;
    logic [3:0] tgt = 0;
    int         checks = 0, passes = 0;
    always #5 clk = ~clk;

    processor_seq_if #(.STATE_W(4)) bus0 ();
    processor_seq_if #(.STATE_W(4)) bus1 ();
    assign bus0.instr_valid = valid;
    assign bus0.instr = op;
    assign bus0.target = tgt;
    assign bus1.instr_valid = valid;
    assign bus1.instr = op;
    assign bus1.target = tgt;

    logic [1:0][3:0] d_st;
    logic [1:0]      d_wrap, d_err, d_done, d_rdy;
    assign d_rdy = {bus1.instr_ready, bus0.instr_ready};

    processor_seq dut0 (.clk(clk), .reset(rst_n), .clk_en(en), .bus(bus0), .state(d_st[0]),
                        .wrap(d_wrap[0]), .err(d_err[0]), .wait_done(d_done[0]));
    processor_seq #(.LAST_STATE(4'd11)) dut1 (.clk(clk), .reset(rst_n), .clk_en(en), .bus(bus1),
                        .state(d_st[1]), .wrap(d_wrap[1]), .err(d_err[1]), .wait_done(d_done[1]));

    int last[2] = '{15, 11};
    int m_st[2], m_left[2];
    bit m_wrap[2], m_err[2], m_done[2];

    // m_left counts remaining stall cycles; the sequencer is ready when it is zero
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_st[k] = 0; m_left[k] = 0; m_wrap[k] = 0; m_err[k] = 0; m_done[k] = 0;
            end else if (en) begin
                m_wrap[k] = 0; m_err[k] = 0; m_done[k] = 0;
                if (m_left[k] > 0) begin
                    m_left[k]--;
                    m_done[k] = m_left[k] == 0;
                end else if (valid) begin
                    case (op)
                        OP_STEP: if (m_st[k] >= last[k]) begin m_st[k] = 0; m_wrap[k] = 1; end
                                 else m_st[k]++;
                        OP_JUMP: if (int'(tgt) <= last[k]) m_st[k] = int'(tgt); else m_err[k] = 1;
                        OP_WAIT: if (tgt == 0) m_done[k] = 1; else m_left[k] = int'(tgt);
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (go) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_state%0d", k), int'(d_st[k]), m_st[k]);
                chk($sformatf("model_ready%0d", k), int'(d_rdy[k]), int'(m_left[k] == 0));
                chk($sformatf("model_wrap%0d", k), int'(d_wrap[k]), int'(m_wrap[k]));
                chk($sformatf("model_err%0d", k), int'(d_err[k]), int'(m_err[k]));
                chk($sformatf("model_done%0d", k), int'(d_done[k]), int'(m_done[k]));
            end
        end
    end

    task automatic drive(bit v, logic [1:0] o, logic [3:0] t, bit e);
        valid = v; op = o; tgt = t; en = e;
        @(posedge clk);
        #2;
    endtask

    initial begin
        en = 1;
        repeat (2) @(posedge clk);
        #2;
        go = 1;
        chk("reset_state", int'(d_st[0]), 0);
        chk("reset_ready", int'(d_rdy[0]), 1);
        chk("reset_pulses", int'({d_wrap[0], d_err[0], d_done[0]}), 0);
        rst_n = 1;
        for (int i = 0; i < 16; i++) begin
            drive(1, OP_STEP, 0, 1);
            chk("step_state", int'(d_st[0]), (i + 1) % 16);
            chk("step_wrap", int'(d_wrap[0]), int'(i == 15));
        end
        chk("step_wrap11", int'(d_st[1]), 4);
        drive(1, OP_JUMP, 9, 1);
        chk("jump9", int'(d_st[1]), 9);
        drive(1, OP_JUMP, 13, 1);
        chk("jump13_kept", int'(d_st[1]), 9);
        chk("jump13_err", int'(d_err[1]), 1);
        chk("jump13_ok", int'(d_st[0]), 13);
        chk("jump13_noerr", int'(d_err[0]), 0);
        drive(1, OP_HOLD, 0, 1);
        chk("err_one_cycle", int'(d_err[1]), 0);
        drive(1, OP_JUMP, 5, 1);
        drive(1, OP_WAIT, 3, 1);
        chk("wait_ready_low", int'(d_rdy[0]), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, OP_STEP, 0, 1);
            chk("wait_done_edge", int'(d_done[0]), int'(i == 2));
            chk("wait_ready", int'(d_rdy[0]), int'(i == 2));
        end
        chk("wait_state", int'(d_st[0]), 5);
        drive(1, OP_STEP, 0, 1);
        chk("step_after_wait", int'(d_st[0]), 6);
        chk("done_cleared", int'(d_done[0]), 0);
        drive(1, OP_WAIT, 2, 1);
        drive(0, OP_HOLD, 0, 0);
        chk("gated_ready", int'(d_rdy[0]), 0);
        drive(0, OP_HOLD, 0, 1);
        chk("gated_no_done", int'(d_done[0]), 0);
        drive(0, OP_HOLD, 0, 0);
        drive(0, OP_HOLD, 0, 1);
        chk("gated_done", int'(d_done[0]), 1);
        drive(0, OP_HOLD, 0, 0);
        chk("done_held_gated", int'(d_done[0]), 1);
        drive(0, OP_HOLD, 0, 1);
        chk("done_after_hold", int'(d_done[0]), 0);
        drive(1, OP_WAIT, 3, 1);
        drive(0, OP_HOLD, 0, 1);
        rst_n = 0;
        #1;
        chk("rst_state", int'(d_st[0]), 0);
        chk("rst_ready", int'(d_rdy[0]), 1);
        chk("rst_done", int'(d_done[0]), 0);
        drive(0, OP_HOLD, 0, 1);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            drive(0, OP_HOLD, 0, 1);
            chk("rst_no_done", int'(d_done[0]), 0);
        end
        drive(1, OP_JUMP, 7, 1);
        drive(1, OP_WAIT, 0, 1);
        chk("wait0_state", int'(d_st[0]), 7);
        chk("wait0_ready", int'(d_rdy[0]), 1);
        chk("wait0_done", int'(d_done[0]), 1);
        drive(1, OP_HOLD, 0, 1);
        chk("hold_state", int'(d_st[0]), 7);
        chk("hold_done", int'(d_done[0]), 0);
        repeat (600) begin
            rst_n = $urandom_range(0, 99) != 0;
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), $urandom_range(0, 4) != 0);
        end
        rst_n = 1;
        drive(0, OP_HOLD, 0, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
